// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 integer pipeline.
//   XLEN / RA_W      : datapath and register-address widths
//   ASRC_* / BSRC_*  : ALU operand-source select encodings
//   id_ex_t          : field bundle held in the ID/EX pipeline register
//   capture_operand  : picks the WB write data over a stale regfile read
package pipe_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    // Encoding 3 of either select is reserved and yields a zero operand.
    localparam logic [1:0] ASRC_RS1  = 2'd0;
    localparam logic [1:0] ASRC_PC   = 2'd1;
    localparam logic [1:0] ASRC_ZERO = 2'd2;

    localparam logic [1:0] BSRC_RS2  = 2'd0;
    localparam logic [1:0] BSRC_IMM  = 2'd1;
    localparam logic [1:0] BSRC_FOUR = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [1:0]      asrc;
        logic [1:0]      bsrc;
        logic [3:0]      aluctr;
        logic [RA_W-1:0] rd_addr;
        logic            reg_wen;
        logic            mem_ren;
        logic            mem_wen;
    } id_ex_t;

    // The register file has no internal write-through, so a value being
    // written back in the same cycle it is read must be taken from WB.
    function automatic logic [XLEN-1:0] capture_operand(
        input logic [RA_W-1:0] rs_addr,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_reg_wen,
        input logic [RA_W-1:0] wb_rd_addr,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] val;
        if (wb_reg_wen && (wb_rd_addr != {RA_W{1'b0}}) && (wb_rd_addr == rs_addr)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register of the EX stage.
//   rs_addr / rs_val         : source register address and value held in ID/EX
//   mem_rd_addr/_reg_wen/_result : producer currently in MEM (non-load result)
//   wb_rd_addr/_reg_wen/_data    : producer currently writing back
//   fwd_val                  : youngest available value for rs_addr
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_val,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic            mem_reg_wen,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_reg_wen,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_val
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs_addr != {RA_W{1'b0}});

    // MEM is younger than WB, so it wins when both target the same register;
    // x0 is hard-wired and never takes a forwarded value.
    always_comb begin
        fwd_val = rs_val;
        if (rs_nonzero_s && mem_reg_wen && (mem_rd_addr == rs_addr)) begin
            fwd_val = mem_result;
        end else if (rs_nonzero_s && wb_reg_wen && (wb_rd_addr == rs_addr)) begin
            fwd_val = wb_data;
        end else begin
            fwd_val = rs_val;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand delivery.
//   ID side  : id_valid/id_ready handshake plus decoded instruction fields
//   Hazards  : flush, MEM and WB producer info for forwarding, load-use stall
//   EX side  : ex_valid/ex_ready handshake, ALU operands, store data and
//              registered controls (write enables gated by ex_valid)
module ex_operand_stage
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_asrc,
    input  logic [1:0]      id_bsrc,
    input  logic [3:0]      id_aluctr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_reg_wen,
    input  logic            id_mem_ren,
    input  logic            id_mem_wen,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic            mem_reg_wen,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_reg_wen,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_da,
    output logic [XLEN-1:0] alu_db,
    output logic [3:0]      alu_aluctr,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_wen,
    output logic            ex_mem_ren,
    output logic            ex_mem_wen
);

    logic            valid_d;
    logic            valid_q;
    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;
    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;
    logic            load_use_s;
    logic            accept_s;

    // A load in EX has no data until after MEM, so a dependent instruction
    // must wait one cycle; both sources are checked regardless of selects.
    assign load_use_s = valid_q && id_ex_q.mem_ren
                     && (id_ex_q.rd_addr != {RA_W{1'b0}})
                     && ((id_ex_q.rd_addr == id_rs1_addr) || (id_ex_q.rd_addr == id_rs2_addr));

    assign id_ready = (!valid_q || ex_ready) && !load_use_s && !flush;
    assign accept_s = id_valid && id_ready;

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr     (id_ex_q.rs1_addr),
        .rs_val      (id_ex_q.rs1),
        .mem_rd_addr (mem_rd_addr),
        .mem_reg_wen (mem_reg_wen),
        .mem_result  (mem_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_reg_wen  (wb_reg_wen),
        .wb_data     (wb_data),
        .fwd_val     (fwd_rs1_s)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr     (id_ex_q.rs2_addr),
        .rs_val      (id_ex_q.rs2),
        .mem_rd_addr (mem_rd_addr),
        .mem_reg_wen (mem_reg_wen),
        .mem_result  (mem_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_reg_wen  (wb_reg_wen),
        .wb_data     (wb_data),
        .fwd_val     (fwd_rs2_s)
    );

    // Next-state of the ID/EX register: flush > accept > bubble > stall hold.
    always_comb begin
        valid_d = valid_q;
        id_ex_d = id_ex_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d          = 1'b1;
            id_ex_d.pc       = id_pc;
            id_ex_d.rs1_addr = id_rs1_addr;
            id_ex_d.rs2_addr = id_rs2_addr;
            id_ex_d.rs1      = capture_operand(id_rs1_addr, id_rs1_data, wb_reg_wen, wb_rd_addr, wb_data);
            id_ex_d.rs2      = capture_operand(id_rs2_addr, id_rs2_data, wb_reg_wen, wb_rd_addr, wb_data);
            id_ex_d.imm      = id_imm;
            id_ex_d.asrc     = id_asrc;
            id_ex_d.bsrc     = id_bsrc;
            id_ex_d.aluctr   = id_aluctr;
            id_ex_d.rd_addr  = id_rd_addr;
            id_ex_d.reg_wen  = id_reg_wen;
            id_ex_d.mem_ren  = id_mem_ren;
            id_ex_d.mem_wen  = id_mem_wen;
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: producers may retire from MEM/WB while we wait, so
            // latch their values now rather than lose them.
            id_ex_d.rs1 = fwd_rs1_s;
            id_ex_d.rs2 = fwd_rs2_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // ID/EX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            id_ex_q <= '0;
        end else begin
            valid_q <= valid_d;
            id_ex_q <= id_ex_d;
        end
    end

    // Operand A select.
    always_comb begin
        alu_da = {XLEN{1'b0}};
        case (id_ex_q.asrc)
            ASRC_RS1:  alu_da = fwd_rs1_s;
            ASRC_PC:   alu_da = id_ex_q.pc;
            ASRC_ZERO: alu_da = {XLEN{1'b0}};
            default:   alu_da = {XLEN{1'b0}};
        endcase
    end

    // Operand B select.
    always_comb begin
        alu_db = {XLEN{1'b0}};
        case (id_ex_q.bsrc)
            BSRC_RS2:  alu_db = fwd_rs2_s;
            BSRC_IMM:  alu_db = id_ex_q.imm;
            BSRC_FOUR: alu_db = XLEN'(3'd4);
            default:   alu_db = {XLEN{1'b0}};
        endcase
    end

    assign ex_valid      = valid_q;
    assign alu_aluctr    = id_ex_q.aluctr;
    assign ex_store_data = fwd_rs2_s;
    assign ex_pc         = id_ex_q.pc;
    assign ex_rd_addr    = id_ex_q.rd_addr;
    assign ex_reg_wen    = valid_q && id_ex_q.reg_wen;
    assign ex_mem_ren    = valid_q && id_ex_q.mem_ren;
    assign ex_mem_wen    = valid_q && id_ex_q.mem_wen;

endmodule
